burn_seq: RTL and testbench

Multi-sector flash burn sequencer. A rising edge on `TRIG` starts the run. For each sector in a contiguous range, the block:

- requests a sector erase,
- waits for the flash to go idle, under a watchdog timeout,
- hands each page of the sector to the page-program engine, one at a time.

It sits between the host/trigger logic and the flash erase and page-program engines. It reports completion, or the sector that failed.

---
 rtl/burn_pkg.sv | 8 +
 rtl/burn_wdog.sv | 20 ++
 rtl/burn_seq.sv | 141 ++++++++++++++
 tb/tb_burn_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/burn_pkg.sv
// burn_pkg: shared FSM encoding and default timeouts for the flash burn blocks
package burn_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_ER_REQ, S_ER_WAIT, S_PG_REQ, S_PG_WAIT, S_NEXT, S_FAIL
  } state_t;
  localparam logic [23:0] ER_TMO = 24'hffffff;
  localparam logic [23:0] PG_TMO = 24'h00ffff;
endpackage

// File: rtl/burn_wdog.sv
// burn_wdog: saturating watchdog counter, expired when the count equals the limit
module burn_wdog #(
  parameter int W = 24
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] lim_i,
  output logic [W-1:0] cnt_o,
  output logic         expired_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  assign cnt_o = cnt_q;
  assign expired_o = cnt_q == lim_i;
endmodule

// File: rtl/burn_seq.sv
// burn_seq: multi-sector flash erase/program sequencer with watchdog timeouts
module burn_seq #(
  parameter int SECT_W = 8,
  parameter int PAGE_W = 4,
  parameter int TMO_W  = 24,
  parameter logic [TMO_W-1:0] ER_TMO = TMO_W'(burn_pkg::ER_TMO),
  parameter logic [TMO_W-1:0] PG_TMO = TMO_W'(burn_pkg::PG_TMO)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     TRIG,
  input  logic [SECT_W-1:0]        START_SECT,
  input  logic [SECT_W-1:0]        NUM_SECT,
  output logic                     ER_REQ,
  output logic [SECT_W-1:0]        ER_ADDR,
  input  logic                     ER_ACK,
  input  logic                     FL_BUSY,
  output logic                     PG_REQ,
  output logic [SECT_W+PAGE_W-1:0] PG_ADDR,
  input  logic                     PG_ACK,
  input  logic                     PG_DONE,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ERR,
  output logic [SECT_W-1:0]        ERR_SECT
);
  import burn_pkg::*;
  state_t                   st_q;
  logic [1:0]               trg_q;
  logic                     strt_q;
  logic [SECT_W-1:0]        sect_q, cnt_q, er_addr_q, err_sect_q;
  logic [PAGE_W-1:0]        page_q;
  logic [SECT_W+PAGE_W-1:0] pg_addr_q;
  logic                     er_req_q, pg_req_q, busy_q, done_q, err_q;
  logic                     wd_clr, wd_en, wd_exp;
  logic [TMO_W-1:0]         wd_cnt, wd_lim;
  assign wd_clr = (st_q == S_ER_REQ && ER_ACK) || (st_q == S_PG_REQ && PG_ACK);
  assign wd_en  = st_q == S_ER_WAIT || st_q == S_PG_WAIT;
  assign wd_lim = st_q == S_ER_WAIT ? ER_TMO : PG_TMO;
  burn_wdog #(.W(TMO_W)) u_wdog (
    .clk_i(CLK), .rst_i(RST), .clr_i(wd_clr), .en_i(wd_en),
    .lim_i(wd_lim), .cnt_o(wd_cnt), .expired_o(wd_exp)
  );
  // Start is registered once more so the FSM answers a TRIG edge on the third clock
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      trg_q  <= '0;
      strt_q <= 1'b0;
    end else begin
      trg_q  <= {trg_q[0], TRIG};
      strt_q <= trg_q[0] & ~trg_q[1] & ~busy_q;
    end
  // Outputs are loaded on the transition into each state, so they are all registered
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      st_q       <= S_IDLE;
      sect_q     <= '0;
      cnt_q      <= '0;
      page_q     <= '0;
      er_req_q   <= 1'b0;
      er_addr_q  <= '0;
      pg_req_q   <= 1'b0;
      pg_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_sect_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (st_q)
        S_IDLE: if (strt_q) begin
          sect_q <= START_SECT;
          cnt_q  <= NUM_SECT;
          err_q  <= 1'b0;
          if (NUM_SECT == '0) done_q <= 1'b1;
          else begin
            st_q      <= S_ER_REQ;
            er_req_q  <= 1'b1;
            er_addr_q <= START_SECT;
            busy_q    <= 1'b1;
          end
        end
        S_ER_REQ: if (ER_ACK) begin
          er_req_q <= 1'b0;
          st_q     <= S_ER_WAIT;
        end
        S_ER_WAIT: if (!FL_BUSY && wd_cnt >= TMO_W'(2)) begin
          page_q    <= '0;
          pg_req_q  <= 1'b1;
          pg_addr_q <= {sect_q, {PAGE_W{1'b0}}};
          st_q      <= S_PG_REQ;
        end else if (wd_exp) begin
          err_q      <= 1'b1;
          err_sect_q <= sect_q;
          busy_q     <= 1'b0;
          st_q       <= S_FAIL;
        end
        S_PG_REQ: if (PG_ACK) begin
          pg_req_q <= 1'b0;
          st_q     <= S_PG_WAIT;
        end
        S_PG_WAIT: if (PG_DONE) begin
          if (&page_q) st_q <= S_NEXT;
          else begin
            page_q    <= page_q + 1'b1;
            pg_req_q  <= 1'b1;
            pg_addr_q <= {sect_q, page_q + 1'b1};
            st_q      <= S_PG_REQ;
          end
        end else if (wd_exp) begin
          err_q      <= 1'b1;
          err_sect_q <= sect_q;
          busy_q     <= 1'b0;
          st_q       <= S_FAIL;
        end
        S_NEXT: begin
          cnt_q  <= cnt_q - 1'b1;
          sect_q <= sect_q + 1'b1;
          if (cnt_q == SECT_W'(1)) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            st_q   <= S_IDLE;
          end else begin
            er_req_q  <= 1'b1;
            er_addr_q <= sect_q + 1'b1;
            st_q      <= S_ER_REQ;
          end
        end
        S_FAIL:  st_q <= S_IDLE;
        default: st_q <= S_IDLE;
      endcase
    end
  assign ER_REQ   = er_req_q;
  assign ER_ADDR  = er_addr_q;
  assign PG_REQ   = pg_req_q;
  assign PG_ADDR  = pg_addr_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign ERR_SECT = err_sect_q;
endmodule

// File: tb/tb_burn_seq.sv
// tb_burn_seq: directed scoreboard bench for burn_seq (PAGE_W=2, ER_TMO=100, PG_TMO=20)
module tb_burn_seq;
  logic        CLK = 1'b0, RST = 1'b1, TRIG = 1'b0;
  logic [7:0]  START_SECT = '0, NUM_SECT = '0;
  logic        ER_ACK = 1'b0, FL_BUSY = 1'b0, PG_ACK = 1'b0, PG_DONE = 1'b0;
  logic        ER_REQ, PG_REQ, BUSY, DONE, ERR;
  logic [7:0]  ER_ADDR, ERR_SECT;
  logic [9:0]  PG_ADDR;
  int          errs = 0, checks = 0;
  logic [31:0] er_q[$], pg_q[$];
  logic        seen;

  burn_seq #(.SECT_W(8), .PAGE_W(2), .TMO_W(24), .ER_TMO(24'd100), .PG_TMO(24'd20)) dut (
    .CLK(CLK), .RST(RST), .TRIG(TRIG), .START_SECT(START_SECT), .NUM_SECT(NUM_SECT),
    .ER_REQ(ER_REQ), .ER_ADDR(ER_ADDR), .ER_ACK(ER_ACK), .FL_BUSY(FL_BUSY),
    .PG_REQ(PG_REQ), .PG_ADDR(PG_ADDR), .PG_ACK(PG_ACK), .PG_DONE(PG_DONE),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ERR_SECT(ERR_SECT)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int s);
    return s == 0 ? ER_REQ : s == 1 ? PG_REQ : DONE;
  endfunction

  task automatic wait_for(input int s, input string tag);
    int n = 0;
    while (sig(s) !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    if (sig(s) !== 1'b1) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic go(input logic [7:0] s, input logic [7:0] n);
    TRIG = 1'b0;
    START_SECT = s;
    NUM_SECT = n;
    repeat (3) tick();
    TRIG = 1'b1;
  endtask

  task automatic er_hs(input int busy_n, input bit tog);
    wait_for(0, "er_req");
    chk("er_addr", ER_ADDR, er_q.size() ? er_q.pop_front() : 32'hdead);
    ER_ACK = 1'b1;
    tick();
    ER_ACK = 1'b0;
    chk("er_req_drop", ER_REQ, 0);
    FL_BUSY = 1'b1;
    for (int i = 0; i < busy_n; i++) begin
      if (tog) TRIG = i >= 2;
      tick();
    end
    FL_BUSY = 1'b0;
  endtask

  task automatic pg_hs;
    wait_for(1, "pg_req");
    chk("pg_addr", PG_ADDR, pg_q.size() ? pg_q.pop_front() : 32'hdead);
    PG_ACK = 1'b1;
    tick();
    PG_ACK = 1'b0;
    chk("pg_req_drop", PG_REQ, 0);
    repeat (2) tick();
    PG_DONE = 1'b1;
    tick();
    PG_DONE = 1'b0;
  endtask

  task automatic serve(input int busy_n, input bit tog);
    er_hs(busy_n, tog);
    repeat (4) pg_hs();
  endtask

  task automatic push_sect(input logic [7:0] s);
    er_q.push_back({24'd0, s});
    for (int p = 0; p < 4; p++) pg_q.push_back({22'd0, s, 2'(p)});
  endtask

  task automatic finish_run(input string tag);
    wait_for(2, tag);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_err"}, ERR, 0);
    tick();
    chk({tag, "_pulse"}, DONE, 0);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_outs", {ER_REQ, ER_ADDR, PG_REQ, PG_ADDR, BUSY, DONE, ERR, ERR_SECT}, 0);
    RST = 1'b0;
    tick();
    // single sector, latency from TRIG edge to erase request
    push_sect(8'h05);
    go(8'h05, 8'h01);
    repeat (2) tick();
    chk("lat_er_early", ER_REQ, 0);
    tick();
    chk("lat_er", ER_REQ, 1);
    chk("lat_busy", BUSY, 1);
    serve(10, 0);
    finish_run("run1_done");
    // TRIG toggled while busy must not start another run
    push_sect(8'h09);
    go(8'h09, 8'h01);
    serve(10, 1);
    finish_run("tog_done");
    seen = 1'b0;
    repeat (8) begin
      tick();
      seen |= ER_REQ | BUSY;
    end
    chk("tog_no_run", seen, 0);
    // sector pointer wraps
    push_sect(8'hFF);
    push_sect(8'h00);
    go(8'hFF, 8'h02);
    serve(5, 0);
    serve(5, 0);
    finish_run("wrap_done");
    chk("queues_empty", er_q.size() + pg_q.size(), 0);
    // erase watchdog expires with flash stuck busy
    er_q.push_back(32'h42);
    go(8'h42, 8'h03);
    wait_for(0, "tmo_er_req");
    chk("tmo_er_addr", ER_ADDR, er_q.pop_front());
    ER_ACK = 1'b1;
    FL_BUSY = 1'b1;
    tick();
    ER_ACK = 1'b0;
    repeat (100) tick();
    chk("tmo_err_early", ERR, 0);
    tick();
    chk("tmo_err", ERR, 1);
    chk("tmo_err_sect", ERR_SECT, 32'h42);
    chk("tmo_busy", BUSY, 0);
    seen = 1'b0;
    repeat (4) begin
      tick();
      seen |= DONE;
    end
    chk("tmo_no_done", seen, 0);
    FL_BUSY = 1'b0;
    // zero-sector run: DONE after three cycles, clears ERR, no requests
    go(8'h03, 8'h00);
    seen = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      seen |= ER_REQ | PG_REQ;
      if (k == 2) chk("zero_done_early", DONE, 0);
      if (k == 3) chk("zero_done", DONE, 1);
      if (k == 3) chk("zero_err_clr", ERR, 0);
      if (k == 4) chk("zero_done_pulse", DONE, 0);
    end
    chk("zero_no_req", seen, 0);
    // PG_DONE on the timeout cycle wins; next page then times out
    er_q.push_back(32'h01);
    pg_q.push_back(32'h04);
    pg_q.push_back(32'h05);
    go(8'h01, 8'h01);
    er_hs(3, 0);
    wait_for(1, "tie_pg_req");
    chk("tie_pg_addr", PG_ADDR, pg_q.pop_front());
    PG_ACK = 1'b1;
    tick();
    PG_ACK = 1'b0;
    repeat (20) tick();
    PG_DONE = 1'b1;
    tick();
    PG_DONE = 1'b0;
    chk("tie_no_err", ERR, 0);
    chk("tie_next_req", PG_REQ, 1);
    chk("tie_next_addr", PG_ADDR, pg_q.pop_front());
    PG_ACK = 1'b1;
    tick();
    PG_ACK = 1'b0;
    repeat (20) tick();
    chk("pgtmo_err_early", ERR, 0);
    tick();
    chk("pgtmo_err", ERR, 1);
    chk("pgtmo_err_sect", ERR_SECT, 32'h01);
    chk("pgtmo_busy", BUSY, 0);
    // asynchronous reset while a page program is outstanding
    er_q.push_back(32'h20);
    pg_q.push_back(32'h80);
    go(8'h20, 8'h01);
    er_hs(3, 0);
    wait_for(1, "rst_pg_req");
    chk("rst_pg_addr", PG_ADDR, pg_q.pop_front());
    PG_ACK = 1'b1;
    tick();
    PG_ACK = 1'b0;
    tick();
    #2 RST = 1'b1;
    #1 chk("rst_async", {ER_REQ, ER_ADDR, PG_REQ, PG_ADDR, BUSY, DONE, ERR, ERR_SECT}, 0);
    tick();
    chk("rst_held", {ER_REQ, PG_REQ, BUSY, DONE}, 0);
    RST = 1'b0;
    push_sect(8'h30);
    go(8'h30, 8'h01);
    serve(4, 0);
    finish_run("post_rst_done");
    chk("final_queues", er_q.size() + pg_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
